// File: rtl/fric_switch_arb.sv
// fric_switch_arb: per-output-port arbiter of the 8-port FRIC switch.
// Eight input ports share one output byte lane. The lane is granted for a
// whole packet at a time and handed out again in round-robin order. This
// block produces the switch mux select and the per-input ready signals.
// It does not carry the data bytes.
//
// Handshake: a byte moves from input gnt_idx to the output lane on every
// cycle where gnt_vld & vld[gnt_idx] & out_rdy are all high (xfer). in_rdy
// and out_vld are combinational views of that same condition. A sender
// must keep its byte stable until it sees in_rdy.
//
// Optional feature: define FRIC_SWITCH_ARB_TIMEOUT_EN to add a stall
// watchdog. The watchdog releases a grant after TIMEOUT_CYCLES consecutive
// granted cycles with no transfer, and pulses timeout when it does so.
// With the macro undefined the grant is held for as long as the stall
// lasts, and timeout is tied low.
module fric_switch_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] vld,
  input  logic [7:0] last,
  input  logic       out_rdy,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic [7:0] in_rdy,
  output logic       out_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic       timeout_q, timeout_d;

  logic       xfer;
  logic       to_expire;
  logic       win_found;
  logic [2:0] win_idx;

  assign xfer = gnt_vld_q & vld[gnt_idx_q] & out_rdy;

  // Round-robin pick: the first requester found scanning from rr_ptr+1 upward, with the index wrapping at 8
  always_comb begin
    logic [2:0] cand;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 1; k <= 8; k++) begin
      cand = rr_ptr_q + 3'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef FRIC_SWITCH_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_expire = (state_q == BUSY) & ~xfer &
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: cleared while idle, so each new grant starts from zero, and cleared again on every transfer
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (xfer) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ (TO_W > 0);
  assign to_expire  = 1'b0;
`endif

  // Next state: a grant is given only from IDLE, and a grant is released on a last byte, on an abort or on a stall timeout
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    rr_ptr_d  = rr_ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = BUSY;
          gnt_d     = 8'b1 << win_idx;
          gnt_idx_d = win_idx;
          gnt_vld_d = 1'b1;
        end
      end
      BUSY: begin
        // An abort takes priority over a timeout, so a dropped request never pulses timeout
        if ((xfer & last[gnt_idx_q]) | ~req[gnt_idx_q]) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          rr_ptr_d  = gnt_idx_q;
        end else if (to_expire) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          rr_ptr_d  = gnt_idx_q;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      rr_ptr_q  <= 3'd7;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      rr_ptr_q  <= rr_ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign in_rdy  = gnt_q & {8{out_rdy}};
  assign out_vld = gnt_vld_q & vld[gnt_idx_q];
  assign timeout = timeout_q;

  // Grant invariants: the grant is never multi-hot, and gnt_vld always matches it
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_vld_eq  : assert property (@(posedge clk) disable iff (rst) gnt_vld_q == (|gnt_q));

endmodule

// File: tb/tb_fric_switch_arb.sv
// tb_fric_switch_arb: directed bench for fric_switch_arb.
// A packet-level model tracks the current owner, the last winner and the
// stall length. A negedge process compares every DUT output against that
// model. Literal checks in the stimulus pin the expected grant sequence.
module tb_fric_switch_arb;

  localparam int TO = 16;
`ifdef FRIC_SWITCH_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] vld = '0;
  logic [7:0] last = '0;
  logic       out_rdy = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic [7:0] in_rdy;
  logic       out_vld;
  logic       timeout;

  always #5 clk = ~clk;

  fric_switch_arb #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .vld(vld), .last(last),
    .out_rdy(out_rdy), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .in_rdy(in_rdy), .out_vld(out_vld), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: owner input (-1 when idle), last winner, stall length, timeout pulse
  int         m_owner = -1;
  int         m_rr = 7;
  int         m_stall = 0;
  logic [2:0] m_idx = '0;
  logic       m_to = 1'b0;

  task automatic model_step();
    bit moved;
    if (rst) begin
      m_owner = -1; m_rr = 7; m_stall = 0; m_idx = '0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 8; k++) begin
          if (m_owner < 0 && req[(m_rr + k) % 8]) begin
            m_owner = (m_rr + k) % 8;
            m_idx   = 3'(m_owner);
            m_stall = 0;
          end
        end
      end else begin
        moved = vld[m_owner] && out_rdy;
        if ((moved && last[m_owner]) || !req[m_owner]) begin
          m_rr = m_owner; m_owner = -1;
        end else if (TO_EN && !moved && m_stall == TO - 1) begin
          m_rr = m_owner; m_owner = -1; m_to = 1'b1;
        end else begin
          m_stall = moved ? 0 : m_stall + 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // scoreboard compare, away from the active edge
  initial forever begin
    logic [7:0] e_gnt;
    @(negedge clk);
    if (cmp_en) begin
      e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      chk("gnt", gnt, e_gnt);
      chk("gnt_idx", {5'b0, gnt_idx}, {5'b0, m_idx});
      chk("gnt_vld", {7'b0, gnt_vld}, {7'b0, (m_owner >= 0)});
      chk("in_rdy", in_rdy, e_gnt & {8{out_rdy}});
      chk("out_vld", {7'b0, out_vld}, {7'b0, (m_owner >= 0) && vld[m_owner]});
      chk("timeout", {7'b0, timeout}, {7'b0, m_to});
    end
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] v, input logic [7:0] l, input logic o);
    req = r; vld = v; last = l; out_rdy = o;
  endtask

  initial begin
    step(2);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_gnt_vld", {7'b0, gnt_vld}, 8'h00);
    chk("rst_gnt_idx", {5'b0, gnt_idx}, 8'h00);
    chk("rst_timeout", {7'b0, timeout}, 8'h00);
    rst = 1'b0;
    cmp_en = 1'b1;
    step();

    // three-byte packet from input 0
    drive(8'h01, 8'h01, 8'h00, 1'b1);
    step();
    chk("t1_gnt", gnt, 8'h01);
    step(2);
    chk("t1_held", gnt, 8'h01);
    last = 8'h01;
    step();
    chk("t1_release", gnt, 8'h00);
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    step();

    // all ports requesting, single-byte packets: idx 1..7,0,1 with bubbles
    drive(8'hFF, 8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t2_idx", {5'b0, gnt_idx}, 8'((1 + k) % 8));
      chk("t2_vld", {7'b0, gnt_vld}, 8'h01);
      step();
      chk("t2_bubble", {7'b0, gnt_vld}, 8'h00);
    end
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    step();

    // park rr_ptr at 2, then req 0A -> idx 3 then idx 1; late req[5] waits
    drive(8'h04, 8'h04, 8'h04, 1'b1);
    step(2);
    drive(8'h0A, 8'h00, 8'h00, 1'b1);
    step();
    chk("t3_idx3", gnt, 8'h08);
    drive(8'h0A, 8'h08, 8'h08, 1'b1);
    step();
    drive(8'h02, 8'h00, 8'h00, 1'b1);
    step();
    chk("t3_idx1", gnt, 8'h02);
    req = 8'h22;
    step(2);
    chk("t3_no_preempt", gnt, 8'h02);
    drive(8'h22, 8'h02, 8'h02, 1'b1);
    step();
    drive(8'h20, 8'h00, 8'h00, 1'b1);
    step();
    chk("t3_idx5", gnt, 8'h20);
    req = 8'h00;
    step();

    // stall on idx 4 with out_rdy low for 10 cycles
    drive(8'h10, 8'h00, 8'h00, 1'b1);
    step();
    chk("t4_idx4", {5'b0, gnt_idx}, 8'h04);
    out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vld = (i % 2 == 1) ? 8'h10 : 8'h00;
      step();
    end
    chk("t4_held", gnt, 8'h10);
    drive(8'h10, 8'h10, 8'h10, 1'b1);
    step();
    chk("t4_release", {7'b0, gnt_vld}, 8'h00);
    drive(8'h00, 8'h00, 8'h00, 1'b1);

    // abort on idx 6; next scan starts at 7
    req = 8'h40;
    step();
    chk("t5_idx6", gnt, 8'h40);
    vld = 8'h40;
    step();
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    step();
    chk("t5_abort", gnt, 8'h00);
    chk("t5_no_to", {7'b0, timeout}, 8'h00);
    req = 8'h81;
    step();
    chk("t5_idx7", gnt, 8'h80);
    req = 8'h00;
    step();

    // stalled packet on idx 0
    drive(8'h01, 8'h00, 8'h00, 1'b1);
    step();
    chk("t6_idx0", gnt, 8'h01);
    if (TO_EN) begin
      step(TO - 1);
      chk("t6_pre_to", gnt, 8'h01);
      step();
      chk("t6_to_gnt", gnt, 8'h00);
      chk("t6_to_pulse", {7'b0, timeout}, 8'h01);
      step();
      chk("t6_to_clear", {7'b0, timeout}, 8'h00);
      chk("t6_regrant", gnt, 8'h01);
    end else begin
      step(20);
      chk("t6_no_release", gnt, 8'h01);
      chk("t6_no_to", {7'b0, timeout}, 8'h00);
    end

    // asynchronous reset mid-packet
    vld = 8'h01;
    #1;
    chk("t7_out_vld_pre", {7'b0, out_vld}, 8'h01);
    rst = 1'b1;
    #1;
    chk("t7_gnt", gnt, 8'h00);
    chk("t7_gnt_idx", {5'b0, gnt_idx}, 8'h00);
    chk("t7_gnt_vld", {7'b0, gnt_vld}, 8'h00);
    chk("t7_in_rdy", in_rdy, 8'h00);
    chk("t7_out_vld", {7'b0, out_vld}, 8'h00);
    chk("t7_timeout", {7'b0, timeout}, 8'h00);
    step(2);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
